// File: rtl/knn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : knn_pkg
//  Purpose  : Shared types and default sizes for the knn sequencer.
//  Revision : 1.0  initial release
// ============================================================================
package knn_pkg;

  localparam int N_SOLVERS_DEF = 10;
  localparam int HW_K_DEF      = 4;

  // Run phases of the sequencer
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_LOAD   = 3'd2,
    ST_GAP1   = 3'd3,
    ST_STREAM = 3'd4,
    ST_GAP2   = 3'd5,
    ST_READ   = 3'd6,
    ST_FIN    = 3'd7
  } state_e;

  // Counter width able to hold 0..n-1 (never narrower than one bit)
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_seq_cnt.sv
`default_nettype none
// ============================================================================
//  Module   : knn_seq_cnt
//  Purpose  : Loadable-to-zero up-counter with terminal-count compare.
//  Revision : 1.0  initial release
// ============================================================================
module knn_seq_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr_i,
  input  logic         inc_i,
  input  logic [W-1:0] tc_val_i,
  output logic [W-1:0] cnt_o,
  output logic         tc_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Clear wins over increment so a phase can restart the count in one cycle
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  // Count register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == tc_val_i);

endmodule
`default_nettype wire

// File: rtl/knn_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : knn_seq_ctrl
//  Purpose  : Run sequencer for the knn datapath: clear, load test points,
//             stream dataset points, then read back the best entries.
//  Revision : 1.0  initial release
// ============================================================================
module knn_seq_ctrl
  import knn_pkg::*;
#(
  parameter  int N_SOLVERS = N_SOLVERS_DEF,
  parameter  int HW_K      = HW_K_DEF,
  parameter  int DATA_W    = 16,
  parameter  int CNT_W     = 16,
  localparam int NSW       = $clog2(N_SOLVERS + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NSW-1:0]       cfg_nsolv,
  input  logic [CNT_W-1:0]     cfg_npts,
  input  logic [N_SOLVERS-1:0] cfg_series,
  output logic                 busy,
  output logic                 done_pulse,
  input  logic                 tp_valid,
  output logic                 tp_ready,
  input  logic [31:0]          tp_data,
  input  logic                 dp_valid,
  output logic                 dp_ready,
  input  logic [31:0]          dp_data,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [DATA_W-1:0]    res_data,
  output logic [15:0]          res_solver,
  output logic [15:0]          res_idx,
  output logic                 res_last,
  output logic                 knn_rst,
  output logic                 knn_valid,
  output logic                 knn_done,
  output logic [15:0]          knn_sel,
  output logic [15:0]          knn_solver_sel,
  output logic                 knn_series_en,
  output logic [31:0]          knn_data_1,
  output logic [31:0]          knn_data_2,
  input  logic [DATA_W-1:0]    knn_data_out
);

  localparam int KW = cnt_width(HW_K);

  state_e                 state_q, state_d;
  logic                   busy_q, busy_d;
  logic                   knn_done_q, knn_done_d;
  logic                   knn_valid_q, knn_valid_d;
  logic                   hold_q, hold_d;
  logic [NSW-1:0]         nsolv_q, nsolv_d;
  logic [CNT_W-1:0]       npts_q, npts_d;
  logic [N_SOLVERS-1:0]   series_q, series_d;
  logic [31:0]            data1_q, data1_d;
  logic [31:0]            data2_q, data2_d;
  logic                   res_valid_q, res_valid_d;
  logic [DATA_W-1:0]      res_data_q, res_data_d;
  logic [15:0]            res_solver_q, res_solver_d;
  logic [15:0]            res_idx_q, res_idx_d;
  logic                   res_last_q, res_last_d;

  // Counters: ld = test-point solver, pt = dataset point, rk = rank, rs = solver
  logic [NSW-1:0]   ld_cnt, rs_cnt;
  logic [CNT_W-1:0] pt_cnt;
  logic [KW-1:0]    rk_cnt;
  logic             ld_tc, pt_tc, rk_tc, rs_tc;
  logic             ld_clr, ld_inc, pt_clr, pt_inc, rk_clr, rk_inc, rs_clr, rs_inc;

  knn_seq_cnt #(.W(NSW)) u_cnt_ld (
    .clk(clk), .rst(rst), .clr_i(ld_clr), .inc_i(ld_inc),
    .tc_val_i(nsolv_q - 1'b1), .cnt_o(ld_cnt), .tc_o(ld_tc)
  );

  knn_seq_cnt #(.W(CNT_W)) u_cnt_pt (
    .clk(clk), .rst(rst), .clr_i(pt_clr), .inc_i(pt_inc),
    .tc_val_i(npts_q - 1'b1), .cnt_o(pt_cnt), .tc_o(pt_tc)
  );

  knn_seq_cnt #(.W(KW)) u_cnt_rk (
    .clk(clk), .rst(rst), .clr_i(rk_clr), .inc_i(rk_inc),
    .tc_val_i(KW'(HW_K - 1)), .cnt_o(rk_cnt), .tc_o(rk_tc)
  );

  knn_seq_cnt #(.W(NSW)) u_cnt_rs (
    .clk(clk), .rst(rst), .clr_i(rs_clr), .inc_i(rs_inc),
    .tc_val_i(nsolv_q - 1'b1), .cnt_o(rs_cnt), .tc_o(rs_tc)
  );

  // Next-state, register updates and per-state handshake outputs
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    knn_done_d   = knn_done_q;
    knn_valid_d  = 1'b0;
    hold_d       = hold_q;
    nsolv_d      = nsolv_q;
    npts_d       = npts_q;
    series_d     = series_q;
    data1_d      = data1_q;
    data2_d      = data2_q;
    res_valid_d  = res_valid_q;
    res_data_d   = res_data_q;
    res_solver_d = res_solver_q;
    res_idx_d    = res_idx_q;
    res_last_d   = res_last_q;
    ld_clr = 1'b0; ld_inc = 1'b0;
    pt_clr = 1'b0; pt_inc = 1'b0;
    rk_clr = 1'b0; rk_inc = 1'b0;
    rs_clr = 1'b0; rs_inc = 1'b0;
    tp_ready       = 1'b0;
    dp_ready       = 1'b0;
    knn_rst        = 1'b0;
    done_pulse     = 1'b0;
    knn_sel        = '0;
    knn_solver_sel = '0;
    knn_series_en  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          // Out-of-range solver counts fall back to the full array
          if (cfg_nsolv == '0 || cfg_nsolv > NSW'(N_SOLVERS)) begin
            nsolv_d = NSW'(N_SOLVERS);
          end else begin
            nsolv_d = cfg_nsolv;
          end
          npts_d   = (cfg_npts == '0) ? CNT_W'(1) : cfg_npts;
          series_d = cfg_series;
          busy_d   = 1'b1;
          state_d  = ST_CLR;
        end
      end

      ST_CLR: begin
        knn_rst = 1'b1;
        ld_clr  = 1'b1;
        hold_d  = 1'b0;
        state_d = ST_LOAD;
      end

      ST_LOAD: begin
        knn_solver_sel = 16'(ld_cnt);
        knn_series_en  = series_q[ld_cnt];
        tp_ready       = !hold_q;
        if (hold_q) begin
          // Data has been presented to solver ld_cnt for one full cycle
          hold_d = 1'b0;
          if (ld_tc) begin
            state_d = ST_GAP1;
          end else begin
            ld_inc = 1'b1;
          end
        end else if (tp_valid) begin
          data1_d = tp_data;
          hold_d  = 1'b1;
        end
      end

      ST_GAP1: begin
        knn_done_d = 1'b0;
        pt_clr     = 1'b1;
        state_d    = ST_STREAM;
      end

      ST_STREAM: begin
        // A strobe cycle always separates two accepted points
        dp_ready = !knn_valid_q;
        if (knn_valid_q) begin
          if (pt_tc) begin
            state_d = ST_GAP2;
          end else begin
            pt_inc = 1'b1;
          end
        end else if (dp_valid) begin
          data2_d     = dp_data;
          knn_valid_d = 1'b1;
        end
      end

      ST_GAP2: begin
        knn_done_d  = 1'b1;
        rk_clr      = 1'b1;
        rs_clr      = 1'b1;
        res_valid_d = 1'b0;
        state_d     = ST_READ;
      end

      ST_READ: begin
        knn_solver_sel = 16'(rs_cnt);
        knn_sel        = 16'(rk_cnt);
        if (!res_valid_q) begin
          // Selects settled this cycle; capture the datapath output
          res_data_d   = knn_data_out;
          res_solver_d = 16'(rs_cnt);
          res_idx_d    = 16'(rk_cnt);
          res_last_d   = rs_tc && rk_tc;
          res_valid_d  = 1'b1;
        end else if (res_ready) begin
          res_valid_d = 1'b0;
          if (res_last_q) begin
            state_d = ST_FIN;
          end else if (rk_tc) begin
            rk_clr = 1'b1;
            rs_inc = 1'b1;
          end else begin
            rk_inc = 1'b1;
          end
        end
      end

      ST_FIN: begin
        done_pulse = 1'b1;
        busy_d     = 1'b0;
        res_last_d = 1'b0;
        state_d    = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset leaves the knn frozen
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      busy_q       <= 1'b0;
      knn_done_q   <= 1'b1;
      knn_valid_q  <= 1'b0;
      hold_q       <= 1'b0;
      nsolv_q      <= NSW'(N_SOLVERS);
      npts_q       <= CNT_W'(1);
      series_q     <= '0;
      data1_q      <= '0;
      data2_q      <= '0;
      res_valid_q  <= 1'b0;
      res_data_q   <= '0;
      res_solver_q <= '0;
      res_idx_q    <= '0;
      res_last_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      knn_done_q   <= knn_done_d;
      knn_valid_q  <= knn_valid_d;
      hold_q       <= hold_d;
      nsolv_q      <= nsolv_d;
      npts_q       <= npts_d;
      series_q     <= series_d;
      data1_q      <= data1_d;
      data2_q      <= data2_d;
      res_valid_q  <= res_valid_d;
      res_data_q   <= res_data_d;
      res_solver_q <= res_solver_d;
      res_idx_q    <= res_idx_d;
      res_last_q   <= res_last_d;
    end
  end

  assign busy       = busy_q;
  assign knn_done   = knn_done_q;
  assign knn_valid  = knn_valid_q;
  assign knn_data_1 = data1_q;
  assign knn_data_2 = data2_q;
  assign res_valid  = res_valid_q;
  assign res_data   = res_data_q;
  assign res_solver = res_solver_q;
  assign res_idx    = res_idx_q;
  assign res_last   = res_last_q;

endmodule
`default_nettype wire

// File: tb/tb_knn_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_knn_seq_ctrl
//  Purpose  : Directed self-checking bench for knn_seq_ctrl.
//  Revision : 1.0  initial release
// ============================================================================
module tb_knn_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_nsolv = '0;
  logic [15:0] cfg_npts = '0;
  logic [9:0]  cfg_series = '0;
  logic        busy, done_pulse;
  logic        tp_valid = 1'b0, tp_ready;
  logic [31:0] tp_data = '0;
  logic        dp_valid = 1'b0, dp_ready;
  logic [31:0] dp_data = '0;
  logic        res_valid, res_ready = 1'b0;
  logic [15:0] res_data, res_solver, res_idx;
  logic        res_last;
  logic        knn_rst, knn_valid, knn_done, knn_series_en;
  logic [15:0] knn_sel, knn_solver_sel;
  logic [31:0] knn_data_1, knn_data_2;
  logic [15:0] knn_data_out;

  int nvec = 0;
  int nerr = 0;

  // Monitor tallies (written only by the monitor process)
  int tp_total = 0, kv_total = 0, rst_total = 0, done_total = 0;
  int kv_bad_seq = 0, kv_bad_data = 0, kv_bad_done = 0;
  int kv_base = 0;
  bit prev_kv = 1'b0;

  always #5 clk = ~clk;

  // Stand-in datapath: each (solver, rank) pair returns a distinct word
  assign knn_data_out = {knn_solver_sel[7:0], knn_sel[7:0]} ^ 16'h5A5A;

  knn_seq_ctrl dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_nsolv(cfg_nsolv), .cfg_npts(cfg_npts), .cfg_series(cfg_series),
    .busy(busy), .done_pulse(done_pulse),
    .tp_valid(tp_valid), .tp_ready(tp_ready), .tp_data(tp_data),
    .dp_valid(dp_valid), .dp_ready(dp_ready), .dp_data(dp_data),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_solver(res_solver), .res_idx(res_idx), .res_last(res_last),
    .knn_rst(knn_rst), .knn_valid(knn_valid), .knn_done(knn_done),
    .knn_sel(knn_sel), .knn_solver_sel(knn_solver_sel),
    .knn_series_en(knn_series_en), .knn_data_1(knn_data_1),
    .knn_data_2(knn_data_2), .knn_data_out(knn_data_out)
  );

  function automatic logic [31:0] exp_pt(input int i);
    logic [15:0] v;
    v = 16'(i);
    return {v, v};
  endfunction

  function automatic logic [15:0] exp_dout(input int s, input int k);
    logic [15:0] v;
    v = {8'(s), 8'(k)};
    return v ^ 16'h5A5A;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Observes strobes and pulses mid-cycle
  always @(negedge clk) begin
    if (knn_valid) begin
      if (prev_kv) kv_bad_seq++;
      if (knn_data_2 !== exp_pt(kv_total - kv_base)) kv_bad_data++;
      if (knn_done !== 1'b0) kv_bad_done++;
      kv_total++;
    end
    prev_kv = knn_valid;
    if (tp_valid && tp_ready) tp_total++;
    if (knn_rst) rst_total++;
    if (done_pulse) done_total++;
  end

  // Full run: start, load, stream, optional abort, readback
  task automatic run(input logic [3:0] nsolv, input logic [15:0] npts,
                     input logic [9:0] series, input bit rnd, input bit poke,
                     input int stall_at, input int stop_at);
    int ns, np, tp0, rst0, dn0, i, t, got, stall;
    logic [15:0] h_data, h_sol, h_idx;
    ns = (nsolv == 4'd0 || nsolv > 4'd10) ? 10 : int'(nsolv);
    np = (npts == 16'd0) ? 1 : int'(npts);
    tp0 = tp_total; rst0 = rst_total; dn0 = done_total; kv_base = kv_total;

    start = 1'b1; cfg_nsolv = nsolv; cfg_npts = npts; cfg_series = series;
    step();
    start = 1'b0;
    chk("clr_knn_rst", 32'(knn_rst), 32'd1);
    chk("clr_busy", 32'(busy), 32'd1);
    step();
    chk("load_knn_rst", 32'(knn_rst), 32'd0);

    for (int c = 0; c < ns; c++) begin
      tp_valid = 1'b1; tp_data = 32'hA000_0000 | 32'(c * 32'h0001_0011);
      t = 0;
      while (!tp_ready && t < 50) begin step(); t++; end
      chk("tp_ready", 32'(tp_ready), 32'd1);
      chk("ld_solver_sel", 32'(knn_solver_sel), 32'(c));
      chk("ld_series_en", 32'(knn_series_en), 32'(series[c]));
      chk("ld_knn_done", 32'(knn_done), 32'd1);
      step();
      tp_valid = 1'b0;
      chk("ld_data_1", knn_data_1, tp_data);
      chk("ld_hold_sel", 32'(knn_solver_sel), 32'(c));
      chk("ld_hold_ready", 32'(tp_ready), 32'd0);
      step();
    end
    chk("tp_count", 32'(tp_total - tp0), 32'(ns));

    if (poke) begin
      // start while busy must not disturb the latched configuration
      start = 1'b1; cfg_nsolv = 4'd3; cfg_npts = 16'd5;
      step();
      start = 1'b0; cfg_nsolv = nsolv; cfg_npts = npts;
      chk("poke_busy", 32'(busy), 32'd1);
      chk("poke_knn_done", 32'(knn_done), 32'd0);
    end

    i = 0; t = 0;
    while (i < np && i != stop_at && t < 6 * np + 100) begin
      dp_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      dp_data  = exp_pt(i);
      if (dp_valid && dp_ready) i++;
      step(); t++;
    end
    dp_valid = 1'b0;

    if (stop_at >= 0) begin
      chk("abort_points", 32'(i), 32'(stop_at));
      rst = 1'b1;
      rst0 = rst_total;
      step();
      chk("abort_state", {28'd0, busy, knn_done, knn_valid, dp_ready}, 32'b0100);
      chk("abort_knn_rst", 32'(knn_rst), 32'd0);
      step();
      rst = 1'b0;
      step();
      chk("abort_no_done", 32'(done_total - dn0), 32'd0);
      chk("abort_no_knn_rst", 32'(rst_total - rst0), 32'd0);
      chk("abort_kv_count", 32'(kv_total - kv_base), 32'(stop_at));
      return;
    end
    chk("dp_count", 32'(i), 32'(np));

    got = 0; t = 0; stall = 0;
    h_data = '0; h_sol = '0; h_idx = '0;
    while (got < ns * 4 && t < 20 * ns + 50) begin
      res_ready = !(got == stall_at && stall < 5);
      if (res_valid && !res_ready) begin
        if (stall > 0) begin
          chk("stall_data", 32'(res_data), 32'(h_data));
          chk("stall_solver", 32'(res_solver), 32'(h_sol));
          chk("stall_idx", 32'(res_idx), 32'(h_idx));
        end
        h_data = res_data; h_sol = res_solver; h_idx = res_idx;
        stall++;
      end else if (res_valid) begin
        chk("res_solver", 32'(res_solver), 32'(got / 4));
        chk("res_idx", 32'(res_idx), 32'(got % 4));
        chk("res_data", 32'(res_data), 32'(exp_dout(got / 4, got % 4)));
        chk("res_last", 32'(res_last), 32'(got == ns * 4 - 1));
        chk("res_knn_done", 32'(knn_done), 32'd1);
        got++;
      end
      step(); t++;
    end
    res_ready = 1'b0;
    chk("res_count", 32'(got), 32'(ns * 4));
    chk("fin_done_pulse", 32'(done_pulse), 32'd1);
    chk("fin_busy", 32'(busy), 32'd1);
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done_pulse", 32'(done_pulse), 32'd0);
    chk("done_count", 32'(done_total - dn0), 32'd1);
    chk("knn_rst_cycles", 32'(rst_total - rst0), 32'd1);
    chk("kv_count", 32'(kv_total - kv_base), 32'(np));
    chk("kv_adjacent", 32'(kv_bad_seq), 32'd0);
    chk("kv_data_2", 32'(kv_bad_data), 32'd0);
    chk("kv_knn_done", 32'(kv_bad_done), 32'd0);
  endtask

  initial begin
    step(); step(); step();
    rst = 1'b0;

    // Idle after reset: frozen knn, everything else low
    for (int j = 0; j < 20; j++) begin
      step();
      chk("reset_outputs",
          {24'd0, knn_done, busy, tp_ready, dp_ready, res_valid, knn_valid, knn_rst, done_pulse},
          32'b1000_0000);
    end

    // Full-size run, max-rate points, stalled consumer, ignored start
    run(4'd10, 16'd1999, 10'b1011011010, 1'b0, 1'b1, 13, -1);
    // Small run with irregular dataset valid
    run(4'd3, 16'd37, 10'b0000000101, 1'b1, 1'b0, 5, -1);
    // Reset while streaming at point 500
    run(4'd2, 16'd1000, 10'b0000000011, 1'b0, 1'b0, -1, 500);
    // Zero configuration clamps to all solvers and a single point
    run(4'd0, 16'd0, 10'b1111111111, 1'b1, 1'b0, 39, -1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
